// File: rtl/and_event_counter_pkg.sv
// Shared types and constants for the AND-reduction event counter and its
// debounce front end.
package and_event_counter_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } debounceState_t;

    // Rail pair encoding: bit 0 is the high rail, bit 1 the low rail.
    localparam logic [1:0] SUPPLY_GOOD = 2'b01;

    function automatic logic supplyIsGood(input logic [1:0] rails);
        return rails == SUPPLY_GOOD;
    endfunction

endpackage

// File: rtl/and_event_counter_if.sv
// Snapshot handshake between the event counter (slave) and its consumer
// (master): the consumer requests a capture and acknowledges with ready.
interface and_event_counter_if #(
    parameter int COUNT_WIDTH = 8
);

    logic                   snapshotRequest;
    logic                   reportReady;
    logic [COUNT_WIDTH-1:0] reportData;
    logic                   reportValid;

    modport master (
        output snapshotRequest,
        output reportReady,
        input  reportData,
        input  reportValid
    );

    modport slave (
        input  snapshotRequest,
        input  reportReady,
        output reportData,
        output reportValid
    );

endinterface

// File: rtl/and_debounce_fsm.sv
// Input conditioning for the AND result: optional two-flop synchroniser
// (AND_EVENT_COUNTER_SYNC_EN) followed by a debounce FSM with a run counter.
module and_debounce_fsm
    import and_event_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic inputData,
    input  logic suppress,
    output logic filteredLevel,
    output logic eventPulse,
    output logic riseAccept
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_CYCLES);

    logic            syncOut;
    debounceState_t  state;
    debounceState_t  stateNext;
    logic [DB_W-1:0] debounceCount;
    logic [DB_W-1:0] countNext;
    logic            levelNext;
    logic            pulseNext;

`ifdef AND_EVENT_COUNTER_SYNC_EN
    logic syncFirst;
    logic syncSecond;

    // Two-flop synchroniser; inputData is asynchronous to Clock in this build.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            syncFirst  <= 1'b0;
            syncSecond <= 1'b0;
        end else begin
            syncFirst  <= inputData;
            syncSecond <= syncFirst;
        end
    end

    assign syncOut = syncSecond;
`else
    assign syncOut = inputData;
`endif

    // State, run counter and the registered level/pulse outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE_LOW;
            debounceCount <= '0;
            filteredLevel <= 1'b0;
            eventPulse    <= 1'b0;
        end else begin
            state         <= stateNext;
            debounceCount <= countNext;
            filteredLevel <= levelNext;
            eventPulse    <= pulseNext;
        end
    end

    // Next-state logic. The first differing sample already counts as one, so
    // a single-cycle debounce accepts straight from the idle state. A rail
    // fault parks the FSM in the idle state matching the current level.
    always_comb begin
        stateNext = state;
        countNext = debounceCount;
        levelNext = filteredLevel;
        pulseNext = 1'b0;
        if (suppress) begin
            stateNext = filteredLevel ? IDLE_HIGH : IDLE_LOW;
            countNext = '0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (syncOut) begin
                        if (DB_ONE == DB_TARGET) begin
                            stateNext = IDLE_HIGH;
                            countNext = '0;
                            levelNext = 1'b1;
                            pulseNext = 1'b1;
                        end else begin
                            stateNext = CHECK_HIGH;
                            countNext = DB_ONE;
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!syncOut) begin
                        stateNext = IDLE_LOW;
                        countNext = '0;
                    end else if (debounceCount + DB_ONE == DB_TARGET) begin
                        stateNext = IDLE_HIGH;
                        countNext = '0;
                        levelNext = 1'b1;
                        pulseNext = 1'b1;
                    end else begin
                        countNext = debounceCount + DB_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!syncOut) begin
                        if (DB_ONE == DB_TARGET) begin
                            stateNext = IDLE_LOW;
                            countNext = '0;
                            levelNext = 1'b0;
                        end else begin
                            stateNext = CHECK_LOW;
                            countNext = DB_ONE;
                        end
                    end
                end
                CHECK_LOW: begin
                    if (syncOut) begin
                        stateNext = IDLE_HIGH;
                        countNext = '0;
                    end else if (debounceCount + DB_ONE == DB_TARGET) begin
                        stateNext = IDLE_LOW;
                        countNext = '0;
                        levelNext = 1'b0;
                    end else begin
                        countNext = debounceCount + DB_ONE;
                    end
                end
                default: begin
                    stateNext = IDLE_LOW;
                    countNext = '0;
                end
            endcase
        end
    end

    // Lets the counter advance on the same edge that registers eventPulse.
    assign riseAccept = pulseNext;

endmodule

// File: rtl/and_event_counter.sv
// Saturating rising-event counter behind the AND reduction, with snapshot
// handshake and rail check. Define AND_EVENT_COUNTER_SYNC_EN to add the
// input synchroniser.
module and_event_counter
    import and_event_counter_pkg::*;
#(
    parameter int COUNT_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [1:0]             DigitSupply,
    input  logic                   inputData,
    input  logic                   clearCount,
    output logic [COUNT_WIDTH-1:0] outputData,
    output logic                   eventPulse,
    output logic                   filteredLevel,
    output logic                   overflow,
    output logic                   supplyFault,
    and_event_counter_if.slave     reportBus
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic                   supplyBad;
    logic                   riseAccept;
    logic [COUNT_WIDTH-1:0] countNext;
    logic                   overflowNext;
    logic                   snapshotAccept;

    assign supplyBad = !supplyIsGood(DigitSupply);

    and_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) debounce (
        .Clock        (Clock),
        .Reset        (Reset),
        .inputData    (inputData),
        .suppress     (supplyBad),
        .filteredLevel(filteredLevel),
        .eventPulse   (eventPulse),
        .riseAccept   (riseAccept)
    );

    // Clear wins over the old value but still counts a coinciding event.
    always_comb begin
        countNext    = outputData;
        overflowNext = overflow;
        if (clearCount) begin
            countNext    = riseAccept ? COUNT_ONE : '0;
            overflowNext = 1'b0;
        end else if (riseAccept) begin
            if (outputData == COUNT_MAX) begin
                overflowNext = 1'b1;
            end else begin
                countNext = outputData + COUNT_ONE;
            end
        end
    end

    // A pending report blocks new requests unless it is being acknowledged.
    assign snapshotAccept = reportBus.snapshotRequest &&
                            (!reportBus.reportValid || reportBus.reportReady);

    // Counter, overflow and rail-fault registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            outputData  <= '0;
            overflow    <= 1'b0;
            supplyFault <= 1'b0;
        end else begin
            outputData  <= countNext;
            overflow    <= overflowNext;
            supplyFault <= supplyBad;
        end
    end

    // Snapshot captures the post-update count so a same-edge event is included.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            reportBus.reportData  <= '0;
            reportBus.reportValid <= 1'b0;
        end else if (snapshotAccept) begin
            reportBus.reportData  <= countNext;
            reportBus.reportValid <= 1'b1;
        end else if (reportBus.reportReady) begin
            reportBus.reportValid <= 1'b0;
        end
    end

endmodule
